// File: rtl/johnson_phase_tracker.sv
// Tracks the phase of a Johnson counter from its sampled state word. It checks
// each sample for a legal hold or single-step advance and reports lock, errors and wrap-around.
module johnson_phase_tracker #(
    parameter int WIDTH      = 8,
    parameter int LOCK_COUNT = 4,
    parameter int ERR_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [WIDTH-1:0]              code_in,
    input  logic                          clear_err,
    output logic [$clog2(2*WIDTH)-1:0]    phase_out,
    output logic                          phase_valid,
    output logic                          locked,
    output logic                          code_err,
    output logic [ERR_W-1:0]              err_count,
    output logic                          wrap_pulse
);

    localparam int PH_W  = $clog2(2*WIDTH);
    localparam int ADV_W = $clog2(LOCK_COUNT + 1);

    localparam logic [1:0] ST_UNLOCKED = 2'd0;
    localparam logic [1:0] ST_ACQUIRE  = 2'd1;
    localparam logic [1:0] ST_LOCKED   = 2'd2;

    // Johnson code for phase k: low k bits set up to k=WIDTH, then the ones drain from the bottom.
    function automatic logic [WIDTH-1:0] phase_code(input int k);
        logic [WIDTH-1:0] ones;
        ones = '1;
        if (k <= WIDTH) return ones >> (WIDTH - k);
        else            return ones << (k - WIDTH);
    endfunction

    logic [WIDTH-1:0] code_q, code_d;
    logic             sample_v_q, sample_v_d;
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] ref_code_q, ref_code_d;
    logic [ADV_W-1:0] adv_cnt_q, adv_cnt_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic             phase_valid_q, phase_valid_d;
    logic             locked_q, locked_d;
    logic             code_err_q, code_err_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic             wrap_q, wrap_d;

    logic             legal;
    logic [PH_W-1:0]  dec_phase;
    logic             is_hold;
    logic             is_adv;
    logic [ADV_W-1:0] adv_inc;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        legal     = 1'b0;
        dec_phase = '0;
        for (int k = 0; k < 2*WIDTH; k++) begin
            if (code_q == phase_code(k)) begin
                legal     = 1'b1;
                dec_phase = PH_W'(k);
            end
        end
        is_hold = (code_q == ref_code_q);
        is_adv  = (code_q == {ref_code_q[WIDTH-2:0], ~ref_code_q[WIDTH-1]});
        adv_inc = adv_cnt_q + 1'b1;
    end

    always_comb begin
        code_d        = code_in;
        sample_v_d    = 1'b1;
        state_d       = state_q;
        ref_code_d    = ref_code_q;
        adv_cnt_d     = adv_cnt_q;
        phase_d       = phase_q;
        phase_valid_d = phase_valid_q;
        code_err_d    = 1'b0;
        wrap_d        = 1'b0;

        if (sample_v_q) begin
            phase_valid_d = legal;
            if (legal) begin
                phase_d    = dec_phase;
                ref_code_d = code_q;
            end
            if (state_q == ST_UNLOCKED) begin
                if (legal) begin
                    adv_cnt_d = '0;
                    state_d   = ST_ACQUIRE;
                end else begin
                    code_err_d = 1'b1;
                end
            end else if (!legal) begin
                code_err_d = 1'b1;
                state_d    = ST_UNLOCKED;
            end else if (is_hold) begin
                state_d = state_q;
            end else if (is_adv) begin
                if (state_q == ST_LOCKED) begin
                    wrap_d = (ref_code_q == phase_code(2*WIDTH-1)) && (code_q == '0);
                end else if (adv_inc == ADV_W'(LOCK_COUNT)) begin
                    state_d   = ST_LOCKED;
                    adv_cnt_d = '0;
                end else begin
                    adv_cnt_d = adv_inc;
                end
            end else begin
                code_err_d = 1'b1;
                adv_cnt_d  = '0;
                state_d    = ST_ACQUIRE;
            end
        end

        // A clear coinciding with a new error leaves that error counted.
        if (clear_err)                    err_count_d = {{(ERR_W-1){1'b0}}, code_err_d};
        else if (code_err_d && !(&err_count_q)) err_count_d = err_count_q + 1'b1;
        else                              err_count_d = err_count_q;

        locked_d = (state_d == ST_LOCKED);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q        <= '0;
            sample_v_q    <= 1'b0;
            state_q       <= ST_UNLOCKED;
            ref_code_q    <= '0;
            adv_cnt_q     <= '0;
            phase_q       <= '0;
            phase_valid_q <= 1'b0;
            locked_q      <= 1'b0;
            code_err_q    <= 1'b0;
            err_count_q   <= '0;
            wrap_q        <= 1'b0;
        end else begin
            code_q        <= code_d;
            sample_v_q    <= sample_v_d;
            state_q       <= state_d;
            ref_code_q    <= ref_code_d;
            adv_cnt_q     <= adv_cnt_d;
            phase_q       <= phase_d;
            phase_valid_q <= phase_valid_d;
            locked_q      <= locked_d;
            code_err_q    <= code_err_d;
            err_count_q   <= err_count_d;
            wrap_q        <= wrap_d;
        end
    end

    assign phase_out   = phase_q;
    assign phase_valid = phase_valid_q;
    assign locked      = locked_q;
    assign code_err    = code_err_q;
    assign err_count   = err_count_q;
    assign wrap_pulse  = wrap_q;

endmodule

// File: tb/tb_johnson_phase_tracker.sv
// Directed bench for johnson_phase_tracker: lock, wrap, hold, illegal code, jump,
// error saturation/clear and asynchronous reset, with hand-computed expectations.
module tb_johnson_phase_tracker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] code_in, code_in_s;
    logic       clear_err, clear_err_s;

    logic [3:0] m_phase, s_phase;
    logic       m_valid, m_locked, m_err, m_wrap;
    logic       s_valid, s_locked, s_err, s_wrap;
    logic [7:0] m_err_count;
    logic [1:0] s_err_count;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    johnson_phase_tracker #(.WIDTH(8), .LOCK_COUNT(4), .ERR_W(8)) u_main (
        .clk(clk), .rst_n(rst_n), .code_in(code_in), .clear_err(clear_err),
        .phase_out(m_phase), .phase_valid(m_valid), .locked(m_locked),
        .code_err(m_err), .err_count(m_err_count), .wrap_pulse(m_wrap)
    );

    johnson_phase_tracker #(.WIDTH(8), .LOCK_COUNT(4), .ERR_W(2)) u_small (
        .clk(clk), .rst_n(rst_n), .code_in(code_in_s), .clear_err(clear_err_s),
        .phase_out(s_phase), .phase_valid(s_valid), .locked(s_locked),
        .code_err(s_err), .err_count(s_err_count), .wrap_pulse(s_wrap)
    );

    function automatic logic [7:0] pack(input logic l, input logic v, input logic e,
                                        input logic w, input logic [3:0] p);
        return {l, v, e, w, p};
    endfunction

    function automatic logic [7:0] m_obs();
        return {m_locked, m_valid, m_err, m_wrap, m_phase};
    endfunction

    function automatic logic [7:0] s_obs();
        return {s_locked, s_valid, s_err, s_wrap, s_phase};
    endfunction

    // Outputs after a step reflect the code presented on the step before.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [7:0] c);
        code_in = c;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; code_in = 8'h00; code_in_s = 8'h00; clear_err = 1'b0; clear_err_s = 1'b0;
        repeat (2) step();
        n_cmp++;
        if (m_obs() !== 8'h00 || m_err_count !== 8'd0) begin
            n_mis++; $display("FAIL reset_main: obs=%h cnt=%0d want obs=00 cnt=0", m_obs(), m_err_count);
        end
        n_cmp++;
        if (s_obs() !== 8'h00 || s_err_count !== 2'd0) begin
            n_mis++; $display("FAIL reset_small: obs=%h cnt=%0d want obs=00 cnt=0", s_obs(), s_err_count);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_lock();
        logic [7:0] codes [5];
        logic [7:0] exp   [5];
        codes = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F};
        exp   = '{pack(0,0,0,0,0), pack(0,1,0,0,0), pack(0,1,0,0,1), pack(0,1,0,0,2), pack(0,1,0,0,3)};
        for (int i = 0; i < 5; i++) begin
            present(codes[i]);
            n_cmp++;
            if (m_obs() !== exp[i]) begin
                n_mis++; $display("FAIL lock_step%0d: obs=%h want %h", i, m_obs(), exp[i]);
            end
        end
        present(8'h1F);
        n_cmp++;
        if (m_obs() !== pack(1,1,0,0,4)) begin
            n_mis++; $display("FAIL lock_done: obs=%h want %h", m_obs(), pack(1,1,0,0,4));
        end
    endtask

    task automatic test_wrap();
        logic [7:0] codes [12];
        logic [3:0] ph    [12];
        logic [7:0] exp;
        codes = '{8'h3F, 8'h7F, 8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'h01};
        ph    = '{4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd0};
        for (int i = 0; i < 12; i++) begin
            present(codes[i]);
            exp = pack(1, 1, 0, (i == 11), ph[i]);
            n_cmp++;
            if (m_obs() !== exp) begin
                n_mis++; $display("FAIL wrap_step%0d: obs=%h want %h", i, m_obs(), exp);
            end
        end
    endtask

    task automatic test_hold();
        present(8'h03);
        n_cmp++;
        if (m_obs() !== pack(1,1,0,0,1)) begin
            n_mis++; $display("FAIL hold_pre1: obs=%h want %h", m_obs(), pack(1,1,0,0,1));
        end
        present(8'h07);
        n_cmp++;
        if (m_obs() !== pack(1,1,0,0,2)) begin
            n_mis++; $display("FAIL hold_pre2: obs=%h want %h", m_obs(), pack(1,1,0,0,2));
        end
        for (int i = 0; i < 5; i++) begin
            present(8'h07);
            n_cmp++;
            if (m_obs() !== pack(1,1,0,0,3) || m_err_count !== 8'd0) begin
                n_mis++; $display("FAIL hold_%0d: obs=%h cnt=%0d want %h cnt=0", i, m_obs(), m_err_count, pack(1,1,0,0,3));
            end
        end
    endtask

    task automatic test_illegal();
        logic [7:0] codes [7];
        logic [7:0] exp   [7];
        codes = '{8'h05, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'h7F};
        exp   = '{pack(1,1,0,0,3), pack(0,0,1,0,3), pack(0,1,0,0,3), pack(0,1,0,0,4),
                  pack(0,1,0,0,5), pack(0,1,0,0,6), pack(1,1,0,0,7)};
        for (int i = 0; i < 7; i++) begin
            present(codes[i]);
            n_cmp++;
            if (m_obs() !== exp[i]) begin
                n_mis++; $display("FAIL illegal_step%0d: obs=%h want %h", i, m_obs(), exp[i]);
            end
            if (i == 1) begin
                n_cmp++;
                if (m_err_count !== 8'd1) begin
                    n_mis++; $display("FAIL illegal_errcnt: got %0d want 1", m_err_count);
                end
            end
        end
    endtask

    task automatic test_jump();
        logic [7:0] codes [11];
        logic [3:0] ph    [11];
        logic [7:0] codes2 [6];
        logic [7:0] exp2   [6];
        logic [7:0] exp;
        codes = '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'h01, 8'h03};
        ph    = '{4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd0, 4'd1};
        for (int i = 0; i < 11; i++) begin
            present(codes[i]);
            exp = pack(1, 1, 0, (i == 9), ph[i]);
            n_cmp++;
            if (m_obs() !== exp) begin
                n_mis++; $display("FAIL jump_walk%0d: obs=%h want %h", i, m_obs(), exp);
            end
        end
        codes2 = '{8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'hFE};
        exp2   = '{pack(1,1,0,0,2), pack(0,1,1,0,4), pack(0,1,0,0,5),
                   pack(0,1,0,0,6), pack(0,1,0,0,7), pack(1,1,0,0,8)};
        for (int i = 0; i < 6; i++) begin
            present(codes2[i]);
            n_cmp++;
            if (m_obs() !== exp2[i]) begin
                n_mis++; $display("FAIL jump_step%0d: obs=%h want %h", i, m_obs(), exp2[i]);
            end
        end
        n_cmp++;
        if (m_err_count !== 8'd2) begin
            n_mis++; $display("FAIL jump_errcnt: got %0d want 2", m_err_count);
        end
    endtask

    task automatic test_err_sat();
        logic [1:0] exp_cnt [6];
        logic       exp_err [6];
        exp_cnt = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        exp_err = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        code_in_s = 8'h05;
        for (int i = 0; i < 6; i++) begin
            step();
            n_cmp++;
            if (s_err_count !== exp_cnt[i] || s_err !== exp_err[i]) begin
                n_mis++; $display("FAIL sat_step%0d: cnt=%0d err=%b want cnt=%0d err=%b",
                                  i, s_err_count, s_err, exp_cnt[i], exp_err[i]);
            end
        end
        code_in_s = 8'h00; clear_err_s = 1'b1;
        step();
        n_cmp++;
        if (s_err_count !== 2'd1 || s_err !== 1'b1) begin
            n_mis++; $display("FAIL clear_with_err: cnt=%0d err=%b want cnt=1 err=1", s_err_count, s_err);
        end
        step();
        n_cmp++;
        if (s_err_count !== 2'd0 || s_err !== 1'b0) begin
            n_mis++; $display("FAIL clear_alone: cnt=%0d err=%b want cnt=0 err=0", s_err_count, s_err);
        end
        clear_err_s = 1'b0;
        n_cmp++;
        if (m_obs() !== pack(1,1,0,0,9) || m_err_count !== 8'd2) begin
            n_mis++; $display("FAIL main_still_locked: obs=%h cnt=%0d want %h cnt=2", m_obs(), m_err_count, pack(1,1,0,0,9));
        end
    endtask

    task automatic test_async_reset();
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (m_obs() !== 8'h00 || m_err_count !== 8'd0) begin
            n_mis++; $display("FAIL async_reset: obs=%h cnt=%0d want obs=00 cnt=0", m_obs(), m_err_count);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        present(8'hFE);
        n_cmp++;
        if (m_obs() !== 8'h00) begin
            n_mis++; $display("FAIL first_after_reset: obs=%h want 00", m_obs());
        end
        present(8'hFE);
        n_cmp++;
        if (m_obs() !== pack(0,1,0,0,9)) begin
            n_mis++; $display("FAIL second_after_reset: obs=%h want %h", m_obs(), pack(0,1,0,0,9));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lock();
        test_wrap();
        test_hold();
        test_illegal();
        test_jump();
        test_err_sat();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
